// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the seq_divider restoring divider.
// SEQ_DIVIDER_SIGNED_EN adds the FIX state used to apply operand signs.
package seq_divider_pkg;

    localparam int DEFAULT_W = 8;

`ifdef SEQ_DIVIDER_SIGNED_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        FIX  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
`endif

    // Counter must reach 2W, hence the +1.
    function automatic int cnt_width(input int w);
        return $clog2(2 * w + 1);
    endfunction

    // Sliced to 2W bits by the user; wide enough for any W up to 32.
    localparam logic [63:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// compare against the divisor, subtract or restore, emit the quotient bit.
module div_step #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_rem,
    input  logic         i_in_bit,
    input  logic [W-1:0] i_divisor,
    output logic [W-1:0] o_rem,
    output logic         o_q_bit
);

    logic [W:0]   w_shift;
    logic [W-1:0] w_diff;

    assign w_shift = {i_rem, i_in_bit};
    assign o_q_bit = (w_shift >= {1'b0, i_divisor});
    // When the subtraction is taken the true difference is below the
    // divisor, so the W-bit wrapped result is exact.
    assign w_diff  = w_shift[W-1:0] - i_divisor;
    assign o_rem   = o_q_bit ? w_diff : w_shift[W-1:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, valid/ready on
// both sides. Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] quotient,
    output logic [W-1:0]   remainder,
    output logic           div_by_zero
);

    localparam int CW = cnt_width(W);

    state_t           r_state;
    state_t           w_next_state;
    logic [2*W-1:0]   r_dvd;
    logic [W-1:0]     r_dvs;
    // Between steps the partial remainder is below the divisor, so W bits
    // hold it; the W+1-bit shifted value lives only inside div_step.
    logic [W-1:0]     r_prem;
    logic [CW-1:0]    r_cnt;
    logic [2*W-1:0]   r_quotient;
    logic [W-1:0]     r_remainder;
    logic             r_dbz;

    logic [W-1:0]     w_step_rem;
    logic             w_q_bit;
    logic [2*W-1:0]   w_dvd_shifted;
    logic             w_last;
    logic             w_dvs_zero;

    div_step #(.W(W)) u_div_step (
        .i_rem     (r_prem),
        .i_in_bit  (r_dvd[2*W-1]),
        .i_divisor (r_dvs),
        .o_rem     (w_step_rem),
        .o_q_bit   (w_q_bit)
    );

    assign w_dvd_shifted = {r_dvd[2*W-2:0], w_q_bit};
    assign w_last        = (r_cnt == CW'(2 * W - 1));
    assign w_dvs_zero    = (r_dvs == '0);

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic           r_neg_q;
    logic           r_neg_r;
    logic           w_dvd_neg;
    logic           w_dvs_neg;
    logic [2*W-1:0] w_dvd_mag;
    logic [W-1:0]   w_dvs_mag;

    assign w_dvd_neg = dividend[2*W-1];
    assign w_dvs_neg = divisor[W-1];
    assign w_dvd_mag = w_dvd_neg ? -dividend : dividend;
    assign w_dvs_mag = w_dvs_neg ? -divisor  : divisor;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path
        // leaves one unassigned, which would infer a latch.
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next_state = RUN;
            end
            RUN: begin
                if (w_dvs_zero) begin
                    w_next_state = DONE;
                end else if (w_last) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                    w_next_state = FIX;
`else
                    w_next_state = DONE;
`endif
                end
            end
`ifdef SEQ_DIVIDER_SIGNED_EN
            FIX: w_next_state = DONE;
`endif
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_prem      <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register here updates
            // from the same pre-edge values, independent of statement order.
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_prem <= '0;
                        r_cnt  <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        // A zero divisor keeps the raw dividend for its remainder.
                        r_dvd   <= (divisor == '0) ? dividend : w_dvd_mag;
                        r_dvs   <= w_dvs_mag;
                        r_neg_q <= w_dvd_neg ^ w_dvs_neg;
                        r_neg_r <= w_dvd_neg;
`else
                        r_dvd  <= dividend;
                        r_dvs  <= divisor;
`endif
                    end
                end
                RUN: begin
                    if (w_dvs_zero) begin
                        r_quotient  <= DBZ_QUOTIENT[2*W-1:0];
                        r_remainder <= r_dvd[W-1:0];
                        r_dbz       <= 1'b1;
                    end else begin
                        r_prem <= w_step_rem;
                        r_dvd  <= w_dvd_shifted;
                        r_cnt  <= r_cnt + CW'(1);
                        if (w_last) begin
                            r_quotient  <= w_dvd_shifted;
                            r_remainder <= w_step_rem;
                            r_dbz       <= 1'b0;
                        end
                    end
                end
`ifdef SEQ_DIVIDER_SIGNED_EN
                FIX: begin
                    // Truncation toward zero; remainder follows the dividend.
                    if (r_neg_q) r_quotient  <= -r_quotient;
                    if (r_neg_r) r_remainder <= -r_remainder;
                end
`endif
                default: ;
            endcase
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (W=8); adds signed vectors
// when SEQ_DIVIDER_SIGNED_EN is defined.
module tb_seq_divider;

`ifdef SEQ_DIVIDER_SIGNED_EN
    localparam int LAT = 17;
`else
    localparam int LAT = 16;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_divider #(.W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one operation, measure edges from acceptance to out_valid,
    // check the result. Leaves the result pending (out_ready low).
    task automatic run_div(input string tag, input logic [15:0] a, input logic [7:0] b,
                           input logic [15:0] exp_q, input logic [7:0] exp_r,
                           input logic exp_dbz, input int exp_lat);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        check({tag, " in_ready_before"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({tag, " in_ready_busy"}, 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
        check({tag, " quotient"}, 32'(quotient), 32'(exp_q));
        check({tag, " remainder"}, 32'(remainder), 32'(exp_r));
        check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(exp_dbz));
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " out_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready_rise"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #12;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset quotient", 32'(quotient), 32'd0);
        check("reset remainder", 32'(remainder), 32'd0);
        check("reset div_by_zero", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1000 / 7, then hold the result under backpressure.
        run_div("1000/7", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, LAT);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0);
            dividend = 16'h1111;
            divisor  = 8'd3;
            @(posedge clk);
            #1;
            check("bp out_valid", 32'(out_valid), 32'd1);
            check("bp in_ready", 32'(in_ready), 32'd0);
            check("bp quotient", 32'(quotient), 32'd142);
            check("bp remainder", 32'(remainder), 32'd6);
        end
        // out_ready with in_valid in DONE must not accept the new operand.
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("bp release out_valid", 32'(out_valid), 32'd0);
        check("bp release in_ready", 32'(in_ready), 32'd1);

`ifdef SEQ_DIVIDER_SIGNED_EN
        run_div("-1/-1", 16'hFFFF, 8'hFF, 16'd1, 8'd0, 1'b0, LAT);
        release_out("-1/-1");
`else
        run_div("65535/255", 16'd65535, 8'd255, 16'd257, 8'd0, 1'b0, LAT);
        release_out("65535/255");
`endif
        run_div("5/200", 16'd5, 8'd200, 16'd0, 8'd5, 1'b0, LAT);
        release_out("5/200");
        run_div("1234/0", 16'd1234, 8'd0, 16'hFFFF, 8'hD2, 1'b1, 1);
        release_out("1234/0");

        // Asynchronous reset in the fifth RUN cycle.
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 16'd1000;
        divisor  = 8'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst in_ready", 32'(in_ready), 32'd1);
        check("midrst quotient", 32'(quotient), 32'd0);
        check("midrst remainder", 32'(remainder), 32'd0);
        check("midrst div_by_zero", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_div("100/3", 16'd100, 8'd3, 16'd33, 8'd1, 1'b0, LAT);
        release_out("100/3");

`ifdef SEQ_DIVIDER_SIGNED_EN
        run_div("-100/7", 16'hFF9C, 8'd7, 16'hFFF2, 8'hFE, 1'b0, LAT);
        release_out("-100/7");
        run_div("100/-7", 16'd100, 8'hF9, 16'hFFF2, 8'h02, 1'b0, LAT);
        release_out("100/-7");
        run_div("min/-1", 16'h8000, 8'hFF, 16'h8000, 8'h00, 1'b0, LAT);
        release_out("min/-1");
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
